// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, multi-cycle MUL/DIV
// occupancy of EX, branch/jump redirect flushes, EX forwarding selects and perf counters.
module hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  Rs1D,
  input  logic [RA_W-1:0]  Rs2D,
  input  logic             UsesRs1D,
  input  logic             UsesRs2D,
  input  logic [RA_W-1:0]  Rs1E,
  input  logic [RA_W-1:0]  Rs2E,
  input  logic [RA_W-1:0]  RdE,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             MulDivE,
  input  logic [RA_W-1:0]  RdM,
  input  logic             RegWriteM,
  input  logic             MemReadM,
  input  logic [RA_W-1:0]  RdW,
  input  logic             RegWriteW,
  input  logic             BranchTakenE,
  input  logic [1:0]       JumpE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam int LUW = 2;
  localparam int MDW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [LUW-1:0] LU_INIT = LUW'(LOAD_LAT - 1);
  localparam logic [MDW-1:0] MD_LAST = MDW'(MD_LAT - 1);

  logic [LUW-1:0]   lu_cnt_q, lu_cnt_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic md_stall, redirect, lu_hit, lu_det, lu_stall, stall_fd;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs) && !MemReadM) return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))         return 2'b01;
    else                                                       return 2'b00;
  endfunction

  always_comb begin
    md_stall = MulDivE && (md_cnt_q != MD_LAST);
    redirect = (BranchTakenE || (JumpE != 2'b00)) && !md_stall;
    lu_hit   = MemReadE && RegWriteE && (RdE != '0) &&
               ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE)));
    // A redirect flushes the dependent ID instruction, so no bubble is needed
    lu_det   = (lu_cnt_q == '0) && lu_hit && !md_stall && !redirect;
    lu_stall = ((lu_cnt_q != '0) || lu_det) && !md_stall;
    stall_fd = md_stall || lu_stall;
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (lu_det)                lu_cnt_d = LU_INIT;
    else if (lu_cnt_q != '0)   lu_cnt_d = lu_cnt_q - 1'b1;
    md_cnt_d = md_stall ? md_cnt_q + 1'b1 : '0;
    stall_d  = (stall_fd && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d  = (redirect && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    MdBusy    = 1'b0;
    if (!rst) begin
      StallF    = stall_fd;
      StallD    = stall_fd;
      StallE    = md_stall;
      FlushD    = redirect;
      FlushE    = redirect || lu_stall;
      FlushM    = md_stall;
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      MdBusy    = md_stall;
    end
  end

  assign StallCycles = stall_q;
  assign FlushEvents = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=32 and LOAD_LAT=2/CNT_W=4)
// checked each cycle against a cycle-indexed behavioural model plus literal spot checks.
module tb_hazard_ctrl;
  localparam int RA_W = 5;
  localparam int MDL  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [RA_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            UsesRs1D, UsesRs2D, RegWriteE, MemReadE, MulDivE;
  logic            RegWriteM, MemReadM, RegWriteW, BranchTakenE;
  logic [1:0]      JumpE;

  logic [1:0]  sf, sd, se, fd, fe, fm, mb;
  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  hazard_ctrl #(.RA_W(RA_W), .LOAD_LAT(1), .MD_LAT(MDL), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .MulDivE(MulDivE), .RdM(RdM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .RdW(RdW),
    .RegWriteW(RegWriteW), .BranchTakenE(BranchTakenE), .JumpE(JumpE),
    .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .MdBusy(mb[0]), .StallCycles(sc0), .FlushEvents(fc0));

  hazard_ctrl #(.RA_W(RA_W), .LOAD_LAT(2), .MD_LAT(MDL), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .MulDivE(MulDivE), .RdM(RdM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .RdW(RdW),
    .RegWriteW(RegWriteW), .BranchTakenE(BranchTakenE), .JumpE(JumpE),
    .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .MdBusy(mb[1]), .StallCycles(sc1), .FlushEvents(fc1));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     cyc = 0;
  int     lu_end [2] = '{0, 0};
  int     md_start = 0;
  bit     md_run = 1'b0;
  longint n_stall [2] = '{0, 0};
  longint n_flush [2] = '{0, 0};

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs && !MemReadM) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    bit mds, red, hit, act, det, lus;
    int elapsed;
    logic [10:0] e, a;
    longint sat, cs, cf;
    elapsed = md_run ? (cyc - md_start) : 0;
    mds = !rst && MulDivE && (elapsed < MDL - 1);
    red = !rst && !mds && (BranchTakenE || JumpE != 2'b00);
    hit = MemReadE && RegWriteE && RdE != 0 &&
          ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));
    for (int k = 0; k < 2; k++) begin
      act = cyc < lu_end[k];
      det = !rst && !act && !mds && !red && hit;
      lus = !rst && !mds && (act || det);
      if (rst) e = {6'b000111, 2'b00, 2'b00, 1'b0};
      else     e = {mds || lus, mds || lus, mds, red, red || lus, mds, m_fwd(Rs1E), m_fwd(Rs2E), mds};
      a = {sf[k], sd[k], se[k], fd[k], fe[k], fm[k], fa[k], fb[k], mb[k]};
      sat = (k == 0) ? 64'hFFFF_FFFF : 64'hF;
      cs = (n_stall[k] > sat) ? sat : n_stall[k];
      cf = (n_flush[k] > sat) ? sat : n_flush[k];
      if (cmp_en) begin
        chk($sformatf("ctl%0d", k), 64'(a), 64'(e));
        chk($sformatf("stallcnt%0d", k), (k == 0) ? 64'(sc0) : 64'(sc1), cs);
        chk($sformatf("flushcnt%0d", k), (k == 0) ? 64'(fc0) : 64'(fc1), cf);
      end
      if (rst) begin
        lu_end[k] = 0; n_stall[k] = 0; n_flush[k] = 0;
      end else begin
        if (det) lu_end[k] = cyc + ((k == 0) ? 1 : 2);
        if (mds || lus) n_stall[k]++;
        if (red) n_flush[k]++;
      end
    end
    if (rst || !MulDivE) md_run = 1'b0;
    else begin
      if (!md_run) begin md_start = cyc; md_run = 1'b1; end
      if (cyc - md_start >= MDL - 1) md_run = 1'b0;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Rs1D = 0; Rs2D = 0; UsesRs1D = 0; UsesRs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RegWriteE = 0; MemReadE = 0; MulDivE = 0; RdM = 0; RegWriteM = 0; MemReadM = 0;
    RdW = 0; RegWriteW = 0; BranchTakenE = 0; JumpE = 2'b00;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ld_use(input logic [RA_W-1:0] rd, input bit u1b, input bit u2b);
    idle();
    MemReadE = 1; RegWriteE = 1; RdE = rd;
    UsesRs1D = u1b; Rs1D = 5; UsesRs2D = u2b; Rs2D = 5;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    #5;
    chk("rst_flush", {fd[0], fe[0], fm[0], sf[0]}, 4'b1110);
    chk("rst_cnt", sc0, 0);
    tick();
    rst = 1'b0;
    tick(2);

    // load-use on Rs1: one bubble for LOAD_LAT=1, two for LOAD_LAT=2
    ld_use(5, 1, 0); #5;
    chk("lu_det", {sf, sd, fe}, 6'b111111);
    tick(); idle(); #5;
    chk("lu_cyc1", sf, 2'b10);
    tick(); #5;
    chk("lu_cyc2", sf, 2'b00);
    chk("lu_cnt0", sc0, 1);
    chk("lu_cnt1", sc1, 2);
    tick();
    ld_use(0, 1, 0); #5; chk("lu_rd0", sf, 2'b00);
    tick();
    ld_use(5, 0, 0); #5; chk("lu_nouse", sf, 2'b00);
    tick();
    ld_use(5, 0, 1); #5; chk("lu_rs2", sf, 2'b11);
    tick(); idle(); tick(2);

    // MUL/DIV held: stall cycles 0-2, release cycle 3
    MulDivE = 1;
    for (int i = 0; i < 3; i++) begin
      #5; chk($sformatf("md_busy%0d", i), {sf[0], sd[0], se[0], fm[0], mb[0], fe[0]}, 6'b111110);
      tick();
    end
    #5; chk("md_rel", {sf[0], se[0], fm[0], mb[0]}, 4'b0000);
    tick(); idle(); #5;
    chk("md_cnt0", sc0, 5);
    chk("md_cnt1", sc1, 7);
    tick();
    MulDivE = 1; tick(8); idle(); #5;
    chk("md_b2b", sc0, 11);
    tick();

    // forwarding
    RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7; #5;
    chk("fwd_mem", {fa[0], fb[0]}, 4'b1010);
    tick(); MemReadM = 1; #5;
    chk("fwd_wb", fa[0], 2'b01);
    tick(); Rs1E = 0; #5;
    chk("fwd_x0", {fa[0], fb[0]}, 4'b0001);
    tick(); MemReadM = 0; RegWriteM = 0; Rs1E = 7; #5;
    chk("fwd_wbonly", fa[1], 2'b01);
    tick(); idle(); tick();

    // redirects
    BranchTakenE = 1; #5;
    chk("br_flush", {fd[0], fe[0], sf[0]}, 3'b110);
    tick(); idle(); JumpE = 2'b10; #5;
    chk("jmp_flush", {fd[1], fe[1]}, 2'b11);
    tick(); idle(); #5;
    chk("flush_ev", fc0, 2);
    chk("flush_noev", fd, 2'b00);
    tick();

    // reset in MUL/DIV cycle 1
    MulDivE = 1; tick();
    rst = 1; tick();
    rst = 0; idle(); #5;
    chk("rst_md_busy", mb, 2'b00);
    chk("rst_md_cnt", sc0, 0);
    chk("rst_md_fcnt", fc1, 0);
    tick();

    // 28 cycles of MUL/DIV -> 21 stalls, saturating at 15 on the 4-bit instance
    MulDivE = 1; tick(28); idle(); #5;
    chk("sat_cnt0", sc0, 21);
    chk("sat_cnt1", sc1, 15);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
